// File: rtl/mod_uart_rx_fifo.sv
// Receive FIFO behind mod_uart_rx: circular byte store with a first-word-fall-through read port.
// Optional sticky lost-byte flag enabled by defining UART_RX_FIFO_OVERRUN_EN.
module mod_uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
`ifdef UART_RX_FIFO_OVERRUN_EN
    ,
    output logic                  overrun,
    input  logic                  overrun_clr
`endif
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_NIL = (ADDR_WIDTH+1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_NIL   = ADDR_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  empty_s;
    logic                  full_s;

    assign empty_s = (count_r == COUNT_NIL);
    assign full_s  = (count_r == COUNT_MAX);
    assign empty   = empty_s;
    assign full    = full_s;
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Accept decisions and next occupancy; a write into a full FIFO is allowed only alongside a pop.
    always_comb begin
        rd_acc_s    = rd_en & ~empty_s;
        wr_acc_s    = rx_done & (~full_s | rd_acc_s);
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + COUNT_ONE;
            2'b01:   count_nxt_s = count_r - COUNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_NIL;
            rd_ptr_r <= PTR_NIL;
            count_r  <= COUNT_NIL;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Data storage is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !reset) begin
            mem_r[wr_ptr_r] <= rx_data;
        end
    end

`ifdef UART_RX_FIFO_OVERRUN_EN
    logic overrun_r;
    assign overrun = overrun_r;

    // Sticky lost-byte flag; a new loss outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (rx_done && full_s && !rd_acc_s) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mod_uart_rx_fifo.sv
// Directed self-checking bench for mod_uart_rx_fifo (default build, overrun checks when enabled).
module tb_mod_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic       overrun;
    logic       overrun_clr;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mod_uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count)
`ifdef UART_RX_FIFO_OVERRUN_EN
        ,
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        rd_en   = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
        overrun_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("rst_overrun", 32'(overrun), 32'd0);
`endif
        reset = 1'b0;

        // single byte
        push(8'hA5);
        check("a5_empty", 32'(empty),   32'd0);
        check("a5_count", 32'(count),   32'd1);
        check("a5_data",  32'(rd_data), 32'hA5);
        pop();
        check("a5_pop_empty", 32'(empty), 32'd1);
        check("a5_pop_count", 32'(count), 32'd0);

        // fill 0x00..0x0F and drain in order
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain_empty", 32'(empty), 32'd1);

        // write while full with no pop: byte dropped
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        push(8'h55);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full",  32'(full),  32'd1);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("ovf_flag", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        push(8'h56);
        overrun_clr = 1'b0;
        check("ovf_set_wins", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("ovf_cleared", 32'(overrun), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf_drain_%0d", i), 32'(rd_data), 32'(8'h20 + i));
            pop();
        end
        check("ovf_drain_empty", 32'(empty), 32'd1);

        // full with simultaneous pop and write
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        rd_en = 1'b1;
        push(8'h77);
        rd_en = 1'b0;
        check("simf_count", 32'(count), 32'd16);
        check("simf_full",  32'(full),  32'd1);
`ifdef UART_RX_FIFO_OVERRUN_EN
        check("simf_no_ovf", 32'(overrun), 32'd0);
`endif
        for (int i = 0; i < 15; i++) begin
            check($sformatf("simf_drain_%0d", i), 32'(rd_data), 32'(8'h41 + i));
            pop();
        end
        check("simf_last", 32'(rd_data), 32'h77);
        pop();
        check("simf_empty", 32'(empty), 32'd1);

        // pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) push(8'(8'h60 + 16 * r + i));
            check($sformatf("wrap_count_%0d", r), 32'(count), 32'd10);
            for (int i = 0; i < 10; i++) begin
                check($sformatf("wrap_%0d_%0d", r, i), 32'(rd_data), 32'(8'h60 + 16 * r + i));
                pop();
            end
        end
        check("wrap_count_end", 32'(count), 32'd0);

        // pop on empty ignored
        pop();
        check("pope_count", 32'(count), 32'd0);
        check("pope_empty", 32'(empty), 32'd1);

        // empty with simultaneous pop and write
        rd_en = 1'b1;
        push(8'h99);
        rd_en = 1'b0;
        check("sime_count", 32'(count),   32'd1);
        check("sime_data",  32'(rd_data), 32'h99);
        pop();

        // asynchronous reset mid-operation
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_count", 32'(count), 32'd0);
        check("arst_full",  32'(full),  32'd0);
        push(8'hEE);
        check("arst_strobe_ignored", 32'(count), 32'd0);
        reset = 1'b0;
        push(8'h3C);
        check("post_rst_count", 32'(count),   32'd1);
        check("post_rst_data",  32'(rd_data), 32'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mod_uart_rx_fifo.md
# mod_uart_rx_fifo

Receive buffer placed directly downstream of `mod_uart_rx`. Captures each byte presented on `rx_data` when `rx_done` pulses, stores it in a circular FIFO, and presents the oldest byte to the consumer through a first-word-fall-through read port with a pop strobe. Decouples the bursty UART byte stream from slower or stalled host logic, and reports overflow.

## Interface
- `DATA_WIDTH`, 8, byte width; matches `rx_data` of the receiver.
- `ADDR_WIDTH`, 4, pointer width; FIFO depth = 2^ADDR_WIDTH = 16 entries.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all control state immediately.
- `rx_data`  input  DATA_WIDTH  received byte from `mod_uart_rx`; sampled only when `rx_done`=1.
- `rx_done`  input  1  one-cycle write strobe from the receiver.
- `rd_en`  input  1  pop strobe from the consumer.
- `rd_data`  output  DATA_WIDTH  head-of-FIFO byte; valid whenever `empty`=0.
- `empty`  output  1  no stored bytes.
- `full`  output  1  2^ADDR_WIDTH bytes stored.
- `count`  output  ADDR_WIDTH+1  number of stored bytes, 0..2^ADDR_WIDTH.
- `overrun`  output  1  sticky lost-byte flag (present only with `UART_RX_FIFO_OVERRUN_EN`).
- `overrun_clr`  input  1  clears `overrun` (present only with `UART_RX_FIFO_OVERRUN_EN`).

## Operation
- Storage: 2^ADDR_WIDTH x DATA_WIDTH array, not reset. Write pointer `wr_ptr`, read pointer `rd_ptr`, each ADDR_WIDTH bits, wrap modulo depth; occupancy held in a separate `count` register (ADDR_WIDTH+1 bits).
- `empty` = (count == 0); `full` = (count == 2^ADDR_WIDTH); both decoded from registered `count`.
- Read accepted (`rd_acc`) = `rd_en` & !`empty`. On accept: `rd_ptr` += 1.
- Write accepted (`wr_acc`) = `rx_done` & (!`full` | `rd_acc`). On accept: mem[`wr_ptr`] <= `rx_data`, `wr_ptr` += 1.
- `count` next = count + wr_acc - rd_acc; both accepted -> unchanged.
- `rd_data` = mem[`rd_ptr`] (asynchronous read, FWFT); don't-care while `empty`=1.
- Pop on empty: ignored, no pointer or count change, no error flag.
- Write while full with no same-cycle pop: byte dropped, memory and pointers unchanged.
- Full with simultaneous pop and write: both accepted, `full` stays 1.
- Empty with simultaneous pop and write: pop ignored, write accepted, `count` -> 1.
- Reset asserted mid-operation: pointers, `count`, `overrun` clear asynchronously; all buffered bytes discarded; strobes during reset ignored.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `overrun`=0; `rd_data` undefined.
- Write latency: `rx_done` sampled at edge N -> `empty`=0, `count` updated, `rd_data` shows the byte after edge N (cycle N+1).
- Pop latency: `rd_en` sampled at edge N -> `rd_data` shows next byte (or `empty`=1) after edge N.
- No combinational path from `rx_done` to any output; `rd_data` depends combinationally only on registered `rd_ptr` and memory.
- `rx_done` may pulse on consecutive cycles; every cycle is an independent write attempt.
- Throughput: one write and one read per cycle.

## Configuration
- `UART_RX_FIFO_OVERRUN_EN` defined: `overrun` and `overrun_clr` ports exist. `overrun` sets on the edge after any `rx_done` with `full`=1 and no `rd_acc`; stays set until `overrun_clr`=1 at an edge. Set and clear in the same cycle -> set wins (`overrun`=1).
- Not defined: both ports absent; dropped bytes discarded silently; all other behaviour identical.

## Test plan
- Reset then write 0xA5 via one `rx_done` pulse -> next cycle `empty`=0, `count`=1, `rd_data`=0xA5; pulse `rd_en` -> `empty`=1, `count`=0.
- Write 0x00..0x0F back-to-back (16 cycles) -> `full`=1, `count`=16; pop 16 times -> `rd_data` sequence 0x00..0x0F in order, then `empty`=1.
- Fill 16, write 0x55 without pop -> `count` stays 16, 0x55 never read; with macro `overrun`=1 until `overrun_clr`, then 0.
- Full FIFO, same-cycle `rd_en` and `rx_done` with 0x77 -> `count` stays 16, `full`=1, 0x77 read out last after 16 pops.
- Pointer wrap: write 10, pop 10, write 10, pop 10 -> data order preserved across wrap, `count` returns to 0.
- Write 3 bytes, assert `reset` asynchronously mid-cycle -> `empty`=1, `count`=0, `full`=0 immediately; after release, next write 0x3C reads back as 0x3C.
